vdp99_cpu_ctl: RTL and testbench

CPU-side access controller for the VDP99 core. It turns Z80 I/O strobes on the two VDP ports (data and control) into VDP register writes, VRAM read/write requests with auto-incrementing address, read-ahead buffering and status-flag clearing. It runs entirely in the pixel clock domain and sits between the Z80 bus glue and the VRAM arbiter / register file. The display fetch engine owns VRAM priority; this block only requests and waits for `vram_ack`.

---
 rtl/vdp99_cpu_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_vdp99_cpu_ctl.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp99_cpu_ctl.sv
`default_nettype none
// ============================================================================
// vdp99_cpu_ctl : Z80 port strobes -> VDP register writes and queued VRAM ops
// Rev 1.0
// ============================================================================
module vdp99_cpu_ctl #(
  parameter int AW = 14
) (
  input  logic          pxclk_i,
  input  logic          reset_n_i,
  input  logic          cpu_mode_i,
  input  logic [7:0]    cpu_din_i,
  input  logic          cpu_wr_i,
  input  logic          cpu_rd_i,
  output logic [7:0]    cpu_dout_o,
  input  logic [7:0]    status_in_i,
  output logic          status_clr_o,
  output logic          reg_we_o,
  output logic [2:0]    reg_addr_o,
  output logic [7:0]    reg_data_o,
  output logic          vram_req_o,
  output logic          vram_we_o,
  output logic [AW-1:0] vram_addr_o,
  output logic [7:0]    vram_wdata_o,
  input  logic          vram_ack_i,
  input  logic [7:0]    vram_rdata_i,
  output logic          overrun_o
);

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } op_t;

  // [0] is the metastable flop, [1] the synchronised level, [2] the delayed copy
  logic [2:0]    wr_sync_q;
  logic [2:0]    rd_sync_q;
  logic          wr_ev_q;
  logic          rd_ev_q;
  logic          wr_mode_q;
  logic          rd_mode_q;
  logic [7:0]    wr_din_q;

  logic          w_wr_rise;
  logic          w_rd_rise;
  logic          w_rd_fall;

  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    tmp_q, tmp_d;
  logic [7:0]    rbuf_q, rbuf_d;
  logic          second_q, second_d;
  op_t           act_q, act_d;
  op_t           pend_q, pend_d;
  logic          reg_we_q, reg_we_d;
  logic [2:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_data_q, reg_data_d;
  logic          status_clr_q, status_clr_d;
  logic          overrun_q, overrun_d;

  op_t [1:0]     w_enq;
  op_t           w_op;

  assign w_wr_rise = wr_sync_q[1] & ~wr_sync_q[2];
  assign w_rd_rise = rd_sync_q[1] & ~rd_sync_q[2];
  assign w_rd_fall = ~rd_sync_q[1] & rd_sync_q[2];

  always_ff @(posedge pxclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_sync_q <= '0;
      rd_sync_q <= '0;
      wr_ev_q   <= 1'b0;
      rd_ev_q   <= 1'b0;
      wr_mode_q <= 1'b0;
      rd_mode_q <= 1'b0;
      wr_din_q  <= '0;
    end else begin
      wr_sync_q <= {wr_sync_q[1:0], cpu_wr_i};
      rd_sync_q <= {rd_sync_q[1:0], cpu_rd_i};
      wr_ev_q   <= w_wr_rise;
      rd_ev_q   <= w_rd_fall;
      if (w_wr_rise) begin
        wr_mode_q <= cpu_mode_i;
        wr_din_q  <= cpu_din_i;
      end
      // The read port is chosen while the strobe is still high; mode may move after it falls
      if (w_rd_rise) begin
        rd_mode_q <= cpu_mode_i;
      end
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    tmp_d        = tmp_q;
    rbuf_d       = rbuf_q;
    second_d     = second_q;
    act_d        = act_q;
    pend_d       = pend_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    status_clr_d = 1'b0;
    overrun_d    = overrun_q;
    w_enq        = '0;
    w_op         = '0;

    // Retire the active op first so a same-cycle enqueue sees the freed slot
    if (act_q.v && vram_ack_i) begin
      if (!act_q.we) begin
        rbuf_d = vram_rdata_i;
      end
      act_d  = pend_q;
      pend_d = '0;
    end

    if (wr_ev_q) begin
      if (wr_mode_q) begin
        if (!second_q) begin
          tmp_d    = wr_din_q;
          second_d = 1'b1;
        end else begin
          second_d = 1'b0;
          if (wr_din_q[7]) begin
            reg_we_d   = 1'b1;
            reg_addr_d = wr_din_q[2:0];
            reg_data_d = tmp_q;
          end else begin
            ptr_d       = AW'({wr_din_q[5:0], tmp_q});
            w_enq[0].v  = ~wr_din_q[6];
            w_enq[0].we = 1'b0;
          end
        end
      end else begin
        second_d      = 1'b0;
        rbuf_d        = wr_din_q;
        w_enq[0].v    = 1'b1;
        w_enq[0].we   = 1'b1;
        w_enq[0].data = wr_din_q;
      end
    end

    if (rd_ev_q) begin
      second_d = 1'b0;
      if (rd_mode_q) begin
        status_clr_d = 1'b1;
      end else begin
        w_enq[1].v  = 1'b1;
        w_enq[1].we = 1'b0;
      end
    end

    // Write-derived op goes ahead of read-derived op; each consumes one pointer step
    for (int i = 0; i < 2; i++) begin
      if (w_enq[i].v) begin
        w_op      = w_enq[i];
        w_op.addr = ptr_d;
        ptr_d     = ptr_d + AW'(1);
        if (!act_d.v) begin
          act_d = w_op;
        end else if (!pend_d.v) begin
          pend_d = w_op;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pxclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q        <= '0;
      tmp_q        <= '0;
      rbuf_q       <= '0;
      second_q     <= 1'b0;
      act_q        <= '0;
      pend_q       <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      status_clr_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      tmp_q        <= tmp_d;
      rbuf_q       <= rbuf_d;
      second_q     <= second_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      status_clr_q <= status_clr_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cpu_dout_o   = cpu_mode_i ? status_in_i : rbuf_q;
  assign status_clr_o = status_clr_q;
  assign reg_we_o     = reg_we_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_data_o   = reg_data_q;
  assign vram_req_o   = act_q.v;
  assign vram_we_o    = act_q.we;
  assign vram_addr_o  = act_q.addr;
  assign vram_wdata_o = act_q.data;
  assign overrun_o    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vdp99_cpu_ctl.sv
`default_nettype none
// ============================================================================
// tb_vdp99_cpu_ctl : directed and randomized checks against a transaction model
// Rev 1.0
// ============================================================================
module tb_vdp99_cpu_ctl;
  localparam int AW = 14;

  logic          clk;
  logic          rst_n;
  logic          cpu_mode;
  logic [7:0]    cpu_din;
  logic          cpu_wr;
  logic          cpu_rd;
  logic [7:0]    cpu_dout;
  logic [7:0]    status_in;
  logic          status_clr;
  logic          reg_we;
  logic [2:0]    reg_addr;
  logic [7:0]    reg_data;
  logic          vram_req;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_wdata;
  logic          vram_ack;
  logic [7:0]    vram_rdata;
  logic          overrun;

  vdp99_cpu_ctl #(.AW(AW)) dut (
    .pxclk_i      (clk),
    .reset_n_i    (rst_n),
    .cpu_mode_i   (cpu_mode),
    .cpu_din_i    (cpu_din),
    .cpu_wr_i     (cpu_wr),
    .cpu_rd_i     (cpu_rd),
    .cpu_dout_o   (cpu_dout),
    .status_in_i  (status_in),
    .status_clr_o (status_clr),
    .reg_we_o     (reg_we),
    .reg_addr_o   (reg_addr),
    .reg_data_o   (reg_data),
    .vram_req_o   (vram_req),
    .vram_we_o    (vram_we),
    .vram_addr_o  (vram_addr),
    .vram_wdata_o (vram_wdata),
    .vram_ack_i   (vram_ack),
    .vram_rdata_i (vram_rdata),
    .overrun_o    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_op_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model
  exp_op_t    exp_q[$];
  int         m_ptr;
  logic [7:0] m_tmp;
  logic       m_second;
  logic [7:0] m_rbuf;
  logic       m_overrun;
  int         exp_reg_cnt;
  logic [2:0] exp_raddr;
  logic [7:0] exp_rdata;
  int         exp_clr_cnt;

  // Observations
  int         reg_cnt;
  int         clr_cnt;
  logic [2:0] last_raddr;
  logic [7:0] last_rdata;
  int         ack_cnt;

  // VRAM responder controls
  logic       ack_en;
  int         ack_delay;
  logic       rand_rdata;
  logic [7:0] fixed_rdata;

  task automatic reset_model();
    exp_q.delete();
    m_ptr = 0; m_tmp = 8'h00; m_second = 1'b0; m_rbuf = 8'h00; m_overrun = 1'b0;
    exp_reg_cnt = 0; exp_raddr = 3'd0; exp_rdata = 8'h00; exp_clr_cnt = 0;
    reg_cnt = 0; clr_cnt = 0; last_raddr = 3'd0; last_rdata = 8'h00; ack_cnt = 0;
  endtask

  task automatic model_enqueue(input logic we, input logic [7:0] d);
    exp_op_t e;
    if (exp_q.size() >= 2) begin
      m_overrun = 1'b1;
    end else begin
      e.we = we; e.addr = AW'(m_ptr); e.data = d;
      exp_q.push_back(e);
    end
    m_ptr = (m_ptr + 1) % (1 << AW);
  endtask

  task automatic model_cpu_write(input logic mode, input logic [7:0] din);
    if (mode) begin
      if (!m_second) begin
        m_tmp = din; m_second = 1'b1;
      end else begin
        m_second = 1'b0;
        if (din[7]) begin
          exp_reg_cnt++; exp_raddr = 3'(din % 8); exp_rdata = m_tmp;
        end else begin
          m_ptr = ((din % 64) * 256 + m_tmp) % (1 << AW);
          if (!din[6]) model_enqueue(1'b0, 8'h00);
        end
      end
    end else begin
      m_second = 1'b0;
      m_rbuf = din;
      model_enqueue(1'b1, din);
    end
  endtask

  task automatic model_cpu_read(input logic mode);
    m_second = 1'b0;
    if (mode) exp_clr_cnt++;
    else model_enqueue(1'b0, 8'h00);
  endtask

  task automatic cpu_write(input logic mode, input logic [7:0] din);
    model_cpu_write(mode, din);
    @(negedge clk);
    cpu_mode = mode; cpu_din = din; cpu_wr = 1'b1;
    repeat (4) @(negedge clk);
    cpu_wr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cpu_read(input logic mode, output logic [7:0] seen);
    model_cpu_read(mode);
    @(negedge clk);
    cpu_mode = mode; cpu_rd = 1'b1;
    repeat (4) @(negedge clk);
    seen = cpu_dout;
    cpu_rd = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (exp_q.size() == 0 && !vram_req) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!done) $display("FAIL drain_%s: outstanding=%0d req=%b, required 0 and 0", tag, exp_q.size(), vram_req);
    else n_pass++;
  endtask

  // Event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reg_we) begin
        reg_cnt++; last_raddr = reg_addr; last_rdata = reg_data;
      end
      if (status_clr) clr_cnt++;
    end
  end

  // VRAM responder: checks each request against the model queue when acking it
  initial begin
    int      wait_cnt;
    exp_op_t e;
    wait_cnt = 0;
    vram_ack = 1'b0;
    vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      vram_ack = 1'b0;
      if (ack_en && vram_req) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL vram_unexpected: got we=%b addr=%h wdata=%h, required no request", vram_we, vram_addr, vram_wdata);
          end else begin
            e = exp_q.pop_front();
            if (vram_we !== e.we || vram_addr !== e.addr || (e.we && vram_wdata !== e.data))
              $display("FAIL vram_op: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                       vram_we, vram_addr, vram_wdata, e.we, e.addr, e.data);
            else n_pass++;
          end
          vram_rdata = rand_rdata ? 8'($urandom) : fixed_rdata;
          if (!vram_we) m_rbuf = vram_rdata;
          vram_ack = 1'b1;
          ack_cnt++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vram_req, vram_we, vram_addr, vram_wdata} !== '0)
      $display("FAIL reset_vram: got req=%b we=%b addr=%h wdata=%h, required all 0", vram_req, vram_we, vram_addr, vram_wdata);
    else n_pass++;
    n_checks++;
    if ({reg_we, reg_addr, reg_data, status_clr, overrun} !== '0)
      $display("FAIL reset_ctl: got we=%b addr=%h data=%h clr=%b ovr=%b, required all 0", reg_we, reg_addr, reg_data, status_clr, overrun);
    else n_pass++;
    n_checks++;
    if (cpu_dout !== 8'h00) $display("FAIL reset_dout: got %h, required 00", cpu_dout);
    else n_pass++;
  endtask

  task automatic test_register_write();
    int req_seen = 0;
    fork
      begin
        repeat (30) begin
          @(negedge clk);
          if (vram_req) req_seen++;
        end
      end
      begin
        cpu_write(1'b1, 8'h70);
        cpu_write(1'b1, 8'h81);
      end
    join
    n_checks++;
    if (reg_cnt !== exp_reg_cnt) $display("FAIL regwr_count: got %0d, required %0d", reg_cnt, exp_reg_cnt);
    else n_pass++;
    n_checks++;
    if (last_raddr !== 3'd1 || last_rdata !== 8'h70)
      $display("FAIL regwr_value: got addr=%0d data=%h, required addr=1 data=70", last_raddr, last_rdata);
    else n_pass++;
    n_checks++;
    if (req_seen !== 0) $display("FAIL regwr_no_vram: got %0d request cycles, required 0", req_seen);
    else n_pass++;
  endtask

  task automatic test_write_setup();
    int acks0;
    logic [7:0] seen;
    ack_en = 1'b1; ack_delay = 4;
    acks0 = ack_cnt;
    cpu_write(1'b1, 8'h00);
    cpu_write(1'b1, 8'h48);
    cpu_write(1'b0, 8'hAA);
    cpu_write(1'b0, 8'h55);
    wait_drain("wrsetup");
    n_checks++;
    if (ack_cnt - acks0 !== 2) $display("FAIL wrsetup_acks: got %0d, required 2", ack_cnt - acks0);
    else n_pass++;
    cpu_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_dout !== 8'h55) $display("FAIL wrsetup_rbuf: got %h, required 55", cpu_dout);
    else n_pass++;
    // next op must land at 0x0802
    cpu_read(1'b0, seen);
    wait_drain("wrsetup_rd");
  endtask

  task automatic test_read_wrap();
    logic [7:0] seen;
    ack_delay = 2; rand_rdata = 1'b0; fixed_rdata = 8'h12;
    cpu_write(1'b1, 8'hFF);
    cpu_write(1'b1, 8'h3F);
    wait_drain("wrap_setup");
    cpu_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_dout !== 8'h12) $display("FAIL wrap_prefetch: got %h, required 12", cpu_dout);
    else n_pass++;
    fixed_rdata = 8'h34;
    cpu_read(1'b0, seen);
    wait_drain("wrap_read");
    n_checks++;
    if (seen !== 8'h12) $display("FAIL wrap_dout_during: got %h, required 12", seen);
    else n_pass++;
    cpu_mode = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_dout !== 8'h34) $display("FAIL wrap_second_read: got %h, required 34", cpu_dout);
    else n_pass++;
    rand_rdata = 1'b1;
  endtask

  task automatic test_status();
    int first_hi, hi_cnt;
    cpu_write(1'b1, 8'h05);
    status_in = 8'h85;
    model_cpu_read(1'b1);
    @(negedge clk);
    cpu_mode = 1'b1; cpu_rd = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cpu_dout !== 8'h85) $display("FAIL status_dout: got %h, required 85", cpu_dout);
    else n_pass++;
    cpu_rd = 1'b0;
    first_hi = -1; hi_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (status_clr) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = k;
      end
    end
    n_checks++;
    if (hi_cnt !== 1 || first_hi !== 4)
      $display("FAIL status_clr_pulse: got %0d pulses first at %0d, required 1 at 4", hi_cnt, first_hi);
    else n_pass++;
    cpu_write(1'b1, 8'h82);
    n_checks++;
    if (reg_cnt !== exp_reg_cnt) $display("FAIL status_second_cleared: got reg writes %0d, required %0d", reg_cnt, exp_reg_cnt);
    else n_pass++;
    cpu_write(1'b1, 8'h87);
    n_checks++;
    if (reg_cnt !== exp_reg_cnt || last_raddr !== exp_raddr || last_rdata !== exp_rdata)
      $display("FAIL status_regwr: got cnt=%0d addr=%0d data=%h, required cnt=%0d addr=%0d data=%h",
               reg_cnt, last_raddr, last_rdata, exp_reg_cnt, exp_raddr, exp_rdata);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int acks0, req_hi;
    logic [7:0] seen;
    ack_en = 1'b0;
    cpu_write(1'b1, 8'h00);
    cpu_write(1'b1, 8'h50);
    for (int k = 0; k < 3; k++) cpu_write(1'b0, 8'($urandom));
    n_checks++;
    if (overrun !== m_overrun || vram_req !== 1'b1)
      $display("FAIL overrun_flag: got ovr=%b req=%b, required ovr=%b req=1", overrun, vram_req, m_overrun);
    else n_pass++;
    acks0 = ack_cnt; req_hi = 0;
    ack_delay = 0; ack_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vram_req) req_hi++;
    end
    n_checks++;
    if (ack_cnt - acks0 !== 2 || req_hi !== 2)
      $display("FAIL overrun_drain: got acks=%0d req_cycles=%0d, required 2 and 2", ack_cnt - acks0, req_hi);
    else n_pass++;
    ack_delay = 1;
    cpu_read(1'b0, seen);
    wait_drain("overrun_rd");
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] seen, exp_seen, d;
    int op;
    ack_en = 1'b1; rand_rdata = 1'b1;
    for (int it = 0; it < 40; it++) begin
      ack_delay = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      d = 8'($urandom);
      case (op)
        0: cpu_write(1'b1, d);
        1: cpu_write(1'b0, d);
        default: begin
          status_in = 8'($urandom);
          exp_seen = (op == 3) ? status_in : m_rbuf;
          cpu_read(op == 3, seen);
          n_checks++;
          if (seen !== exp_seen) $display("FAIL rand_dout_strobe: it=%0d got %h, required %h", it, seen, exp_seen);
          else n_pass++;
        end
      endcase
      wait_drain("rand");
      cpu_mode = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_dout !== m_rbuf) $display("FAIL rand_rbuf: it=%0d got %h, required %h", it, cpu_dout, m_rbuf);
      else n_pass++;
      n_checks++;
      if (reg_cnt !== exp_reg_cnt || clr_cnt !== exp_clr_cnt || overrun !== m_overrun)
        $display("FAIL rand_events: it=%0d got reg=%0d clr=%0d ovr=%b, required reg=%0d clr=%0d ovr=%b",
                 it, reg_cnt, clr_cnt, overrun, exp_reg_cnt, exp_clr_cnt, m_overrun);
      else n_pass++;
      if (op == 0 && exp_reg_cnt > 0) begin
        n_checks++;
        if (last_raddr !== exp_raddr || last_rdata !== exp_rdata)
          $display("FAIL rand_regwr: it=%0d got addr=%0d data=%h, required addr=%0d data=%h",
                   it, last_raddr, last_rdata, exp_raddr, exp_rdata);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int req_hi = 0;
    ack_en = 1'b0;
    cpu_write(1'b0, 8'hC3);
    cpu_write(1'b0, 8'h3C);
    n_checks++;
    if (vram_req !== 1'b1) $display("FAIL rstmid_pre: got req=%b, required 1", vram_req);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vram_req !== 1'b0) $display("FAIL rstmid_async: got req=%b, required 0", vram_req);
    else n_pass++;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (vram_req) req_hi++;
    end
    n_checks++;
    if (req_hi !== 0) $display("FAIL rstmid_stale: got %0d request cycles, required 0", req_hi);
    else n_pass++;
    cpu_mode = 1'b0;
    #1;
    n_checks++;
    if ({vram_we, vram_addr, vram_wdata, reg_we, reg_addr, reg_data, status_clr, overrun, cpu_dout} !== '0)
      $display("FAIL rstmid_outputs: got we=%b addr=%h wdata=%h ovr=%b dout=%h, required all 0",
               vram_we, vram_addr, vram_wdata, overrun, cpu_dout);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_mode = 1'b0; cpu_din = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
    status_in = 8'h00; rst_n = 1'b0;
    ack_en = 1'b0; ack_delay = 0; rand_rdata = 1'b1; fixed_rdata = 8'h00;
    reset_model();
    test_reset();
    test_register_write();
    test_write_setup();
    test_read_wrap();
    test_status();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
